if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage ARMv8-M pipeline. Owns the PC and drives the

---
 rtl/if_stage.sv | 198 +++++++++++++++++++
 tb/tb_if_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the 5-stage ARMv8-M pipeline.
//
// Owns the program counter and presents its word address to an instruction
// memory with a combinational read port. The returned word is captured into
// the IF/ID pipeline register together with its byte address and address+4.
// Supports decode stalls, branch/exception redirects (which squash IF/ID) and
// a fetch-enable gate used while the instruction memory is being loaded.
//
// Optional feature: define FETCH_PERF_EN to add saturating performance
// counters for delivered instructions and bubble cycles.
//
// Parameters
//   RESET_PC  byte address loaded into the PC on reset
//   AW        instruction-memory word-address width
//   DW        instruction word width
//
// Ports
//   clk_i            clock, all state updates on the rising edge
//   rst_i            synchronous active-high reset
//   fetch_en_i       1 = fetching permitted, 0 = hold PC and issue bubbles
//   stall_i          decode hazard stall, hold PC and IF/ID
//   redirect_i       taken branch / exception, load redirect_pc_i, squash IF/ID
//   redirect_pc_i    new fetch byte address (low two bits ignored)
//   imem_addr_o      word address to instruction memory (pc[AW+1:2])
//   imem_dout_i      instruction word read combinationally at imem_addr_o
//   if_id_valid_o    IF/ID holds a real instruction
//   if_id_pc_o       byte address of if_id_instr_o
//   if_id_pc4_o      if_id_pc_o + 4
//   if_id_instr_o    fetched instruction
//   perf_fetch_o     (FETCH_PERF_EN) valid instructions delivered
//   perf_bubble_o    (FETCH_PERF_EN) cycles IF/ID was loaded with a bubble
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          AW       = 9,
    parameter int          DW       = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          fetch_en_i,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [31:0]   redirect_pc_i,
    output logic [AW-1:0] imem_addr_o,
    input  logic [DW-1:0] imem_dout_i,
    output logic          if_id_valid_o,
    output logic [31:0]   if_id_pc_o,
    output logic [31:0]   if_id_pc4_o,
    output logic [DW-1:0] if_id_instr_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetch_o,
    output logic [31:0]   perf_bubble_o
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          valid_q, valid_d;
    logic [31:0]   id_pc_q, id_pc_d;
    logic [31:0]   id_pc4_q, id_pc4_d;
    logic [DW-1:0] id_instr_q, id_instr_d;

    // Word address into imem; wider PCs alias modulo the memory size.
    assign imem_addr_o = pc_q[AW+1:2];

    assign if_id_valid_o = valid_q;
    assign if_id_pc_o    = id_pc_q;
    assign if_id_pc4_o   = id_pc4_q;
    assign if_id_instr_o = id_instr_q;

    // Next-state logic: FSM transition plus the per-cycle redirect/stall/idle/advance action.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_instr_d = id_instr_q;

        case (state_q)
            ST_IDLE: begin
                if (fetch_en_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!fetch_en_i && !redirect_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The action taken this cycle is decided by the current state, so the
        // instruction fetched on the cycle fetch_en drops is still delivered.
        if (redirect_i) begin
            // Masking instead of slicing keeps every redirect bit consumed.
            pc_d    = redirect_pc_i & 32'hFFFF_FFFC;
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else if (stall_i) begin
            pc_d    = pc_q;
            valid_d = valid_q;
        end else if (state_q == ST_IDLE) begin
            pc_d    = pc_q;
            valid_d = 1'b0;
        end else begin
            id_pc_d    = pc_q;
            id_pc4_d   = pc_q + 32'd4;
            id_instr_d = imem_dout_i;
            valid_d    = 1'b1;
            pc_d       = pc_q + 32'd4;
        end
    end

    // PC, FSM and IF/ID pipeline register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            id_pc_q    <= 32'h0000_0000;
            id_pc4_q   <= 32'h0000_0000;
            id_instr_q <= {DW{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_instr_q <= id_instr_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic        advance_s;
    logic        bubble_s;
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_bubble_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        logic [31:0] r;
        if (v == 32'hFFFF_FFFF) begin
            r = v;
        end else begin
            r = v + 32'd1;
        end
        return r;
    endfunction

    // Event decode: a bubble is any cycle IF/ID is loaded invalid; stalls load nothing.
    always_comb begin
        advance_s = 1'b0;
        bubble_s  = 1'b0;
        if (redirect_i) begin
            bubble_s = 1'b1;
        end else if (stall_i) begin
            bubble_s = 1'b0;
        end else if (state_q == ST_IDLE) begin
            bubble_s = 1'b1;
        end else begin
            advance_s = 1'b1;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fetch_q  <= 32'h0000_0000;
            perf_bubble_q <= 32'h0000_0000;
        end else begin
            if (advance_s) begin
                perf_fetch_q <= sat_inc(perf_fetch_q);
            end
            if (bubble_s) begin
                perf_bubble_q <= sat_inc(perf_bubble_q);
            end
        end
    end

    assign perf_fetch_o  = perf_fetch_q;
    assign perf_bubble_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : self-checking bench for if_stage.
// A directed vector table covers reset, sequential fetch, stall, redirect with
// stall, fetch_en gating and mid-run reset; hand sequences cover imem aliasing
// and PC wrap; a randomized phase compares against a behavioural model.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam logic [31:0] K = 32'hC0DE_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_en;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_dout;
    logic          if_id_valid;
    logic [31:0]   if_id_pc;
    logic [31:0]   if_id_pc4;
    logic [DW-1:0] if_id_instr;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetch;
    logic [31:0]   perf_bubble;
`endif

    logic [31:0] imem [512];
    assign imem_dout = imem[imem_addr];

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000), .AW(AW), .DW(DW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .fetch_en_i    (fetch_en),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_dout_i   (imem_dout),
        .if_id_valid_o (if_id_valid),
        .if_id_pc_o    (if_id_pc),
        .if_id_pc4_o   (if_id_pc4),
        .if_id_instr_o (if_id_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_o  (perf_fetch),
        .perf_bubble_o (perf_bubble)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock with the given inputs; returns #1 after the edge.
    task automatic cyc(input logic r, input logic fe, input logic st,
                       input logic rd, input logic [31:0] rpc);
        rst = r; fetch_en = fe; stall = st; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] pc4, input logic [31:0] instr,
                           input logic [31:0] addr);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
        chk({tag, ".pc"},    if_id_pc,    pc);
        chk({tag, ".pc4"},   if_id_pc4,   pc4);
        chk({tag, ".instr"}, if_id_instr, instr);
        chk({tag, ".addr"},  {23'd0, imem_addr}, addr);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, fe, st, rd;
        logic [31:0] rpc;
        logic        v;
        logic [31:0] pc, pc4, instr, addr, pf, pb;
    } vec_t;

    function automatic vec_t mk(logic r, logic fe, logic st, logic rd, logic [31:0] rpc,
                                logic v, logic [31:0] pc, logic [31:0] pc4,
                                logic [31:0] instr, logic [31:0] addr,
                                logic [31:0] pf, logic [31:0] pb);
        vec_t x;
        x.rst = r; x.fe = fe; x.st = st; x.rd = rd; x.rpc = rpc;
        x.v = v; x.pc = pc; x.pc4 = pc4; x.instr = instr; x.addr = addr;
        x.pf = pf; x.pb = pb;
        return x;
    endfunction

    vec_t vecs [15];

    // ---------------- behavioural model ----------------
    logic        m_run;
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
    logic        m_v;
    longint      m_pf, m_pb;

    task automatic model_step(input logic r, input logic fe, input logic st,
                              input logic rd, input logic [31:0] rpc);
        if (r) begin
            m_run = 1'b0; m_pc = 32'h0; m_v = 1'b0;
            m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = 32'h0;
            m_pf = 0; m_pb = 0;
        end else if (rd) begin
            m_pc  = {rpc[31:2], 2'b00};
            m_v   = 1'b0;
            m_pb  = m_pb + 1;
            m_run = 1'b1;
        end else begin
            if (!st) begin
                if (!m_run) begin
                    m_v  = 1'b0;
                    m_pb = m_pb + 1;
                end else begin
                    m_ipc   = m_pc;
                    m_ipc4  = m_pc + 32'd4;
                    m_instr = imem[m_pc[10:2]];
                    m_v     = 1'b1;
                    m_pc    = m_pc + 32'd4;
                    m_pf    = m_pf + 1;
                end
            end
            // Without a redirect, fetch permission alone sets next cycle's mode.
            m_run = fe;
        end
        if (m_pf > 64'hFFFF_FFFF) m_pf = 64'hFFFF_FFFF;
        if (m_pb > 64'hFFFF_FFFF) m_pb = 64'hFFFF_FFFF;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) imem[i] = K | i;

        vecs[0]  = mk(0,1,0,0,32'h0,  0, 32'h00,32'h00,32'h0,   32'h00, 0,1);
        vecs[1]  = mk(0,1,0,0,32'h0,  1, 32'h00,32'h04,K|32'h0, 32'h01, 1,1);
        vecs[2]  = mk(0,1,0,0,32'h0,  1, 32'h04,32'h08,K|32'h1, 32'h02, 2,1);
        vecs[3]  = mk(0,1,1,0,32'h0,  1, 32'h04,32'h08,K|32'h1, 32'h02, 2,1);
        vecs[4]  = mk(0,1,1,0,32'h0,  1, 32'h04,32'h08,K|32'h1, 32'h02, 2,1);
        vecs[5]  = mk(0,1,1,0,32'h0,  1, 32'h04,32'h08,K|32'h1, 32'h02, 2,1);
        vecs[6]  = mk(0,1,0,0,32'h0,  1, 32'h08,32'h0C,K|32'h2, 32'h03, 3,1);
        vecs[7]  = mk(0,1,0,0,32'h0,  1, 32'h0C,32'h10,K|32'h3, 32'h04, 4,1);
        vecs[8]  = mk(0,1,1,1,32'h43, 0, 32'h0C,32'h10,K|32'h3, 32'h10, 4,2);
        vecs[9]  = mk(0,1,0,0,32'h0,  1, 32'h40,32'h44,K|32'h10,32'h11, 5,2);
        vecs[10] = mk(0,0,0,0,32'h0,  1, 32'h44,32'h48,K|32'h11,32'h12, 6,2);
        vecs[11] = mk(0,0,0,0,32'h0,  0, 32'h44,32'h48,K|32'h11,32'h12, 6,3);
        vecs[12] = mk(0,1,0,0,32'h0,  0, 32'h44,32'h48,K|32'h11,32'h12, 6,4);
        vecs[13] = mk(0,1,0,0,32'h0,  1, 32'h48,32'h4C,K|32'h12,32'h13, 7,4);
        vecs[14] = mk(1,1,1,1,32'h100,0, 32'h00,32'h00,32'h0,   32'h00, 0,0);

        // Reset state
        cyc(1,1,0,0,32'h0);
        cyc(1,1,0,0,32'h0);
        chk_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef FETCH_PERF_EN
        chk("reset.perf_fetch",  perf_fetch,  32'h0);
        chk("reset.perf_bubble", perf_bubble, 32'h0);
`endif

        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].rst, vecs[i].fe, vecs[i].st, vecs[i].rd, vecs[i].rpc);
            chk_all($sformatf("vec%0d", i), vecs[i].v, vecs[i].pc, vecs[i].pc4,
                    vecs[i].instr, vecs[i].addr);
`ifdef FETCH_PERF_EN
            chk($sformatf("vec%0d.perf_fetch", i),  perf_fetch,  vecs[i].pf);
            chk($sformatf("vec%0d.perf_bubble", i), perf_bubble, vecs[i].pb);
`endif
        end

        // imem aliasing at the top of the word space
        cyc(0,1,0,1,32'h7F8);
        chk_all("alias.redir", 1'b0, 32'h0, 32'h0, 32'h0, 32'h1FE);
        cyc(0,1,0,0,32'h0);
        chk_all("alias.7f8", 1'b1, 32'h7F8, 32'h7FC, K|32'h1FE, 32'h1FF);
        cyc(0,1,0,0,32'h0);
        chk_all("alias.7fc", 1'b1, 32'h7FC, 32'h800, K|32'h1FF, 32'h000);
        cyc(0,1,0,0,32'h0);
        chk_all("alias.800", 1'b1, 32'h800, 32'h804, K|32'h0, 32'h001);

        // PC wrap modulo 2^32, with low redirect bits discarded
        cyc(0,1,0,1,32'hFFFF_FFFE);
        chk_all("wrap.redir", 1'b0, 32'h800, 32'h804, K|32'h0, 32'h1FF);
        cyc(0,1,0,0,32'h0);
        chk_all("wrap.top", 1'b1, 32'hFFFF_FFFC, 32'h0, K|32'h1FF, 32'h000);

        // Randomized phase against the behavioural model
        for (int i = 0; i < 512; i++) imem[i] = $urandom;
        cyc(1,0,0,0,32'h0);
        model_step(1,0,0,0,32'h0);
        for (int n = 0; n < 1500; n++) begin
            logic r, fe, st, rd;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 59) == 0);
            fe  = ($urandom_range(0, 5) != 0);
            st  = ($urandom_range(0, 4) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = $urandom;
            cyc(r, fe, st, rd, rpc);
            model_step(r, fe, st, rd, rpc);
            chk_all("rand", m_v, m_ipc, m_ipc4, m_instr, {23'd0, m_pc[10:2]});
`ifdef FETCH_PERF_EN
            chk("rand.perf_fetch",  perf_fetch,  m_pf[31:0]);
            chk("rand.perf_bubble", perf_bubble, m_pb[31:0]);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
